// File: rtl/idli_utq_if.sv
// Slice-serial handshake bundle between execution unit, UART TX queue and UART TX.
// The slave side is the queue; the master side drives writes and accepts reads.
interface idli_utq_if;
   logic [3:0] i_utq_data;
   logic       i_utq_vld;
   logic       o_utq_acp;
   logic [3:0] o_utq_data;
   logic       o_utq_vld;
   logic       i_utq_acp;

   modport master (
      output i_utq_data, i_utq_vld, i_utq_acp,
      input  o_utq_acp, o_utq_data, o_utq_vld
   );

   modport slave (
      input  i_utq_data, i_utq_vld, i_utq_acp,
      output o_utq_acp, o_utq_data, o_utq_vld
   );
endinterface

// File: rtl/idli_utq_m.sv
// UART TX queue: 16b words in/out as four 4b slices per period, zero added read latency; o_utq_acp stalls the writer when full.
// Optional synchronous flush port i_utq_flush is enabled by defining IDLI_UTQ_FLUSH_EN.
module idli_utq_m #(
   parameter int DEPTH = 4
) (
   input  logic       i_utq_gck,
   input  logic       i_utq_rst,
   input  logic [1:0] i_utq_ctr,
`ifdef IDLI_UTQ_FLUSH_EN
   input  logic       i_utq_flush,
`endif
   idli_utq_if.slave  utq
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [15:0]   mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          abort;
   logic          last;
   logic          push_ok;
   logic          push_fire;
   logic          pop_fire;
   logic          flush;

   assign last          = &i_utq_ctr;
   assign utq.o_utq_acp = (count != FULL);
   assign utq.o_utq_vld = (count != '0);
   assign push_ok       = utq.i_utq_vld && utq.o_utq_acp;
   // A reset mid-period leaves abort set so the tail of that period cannot commit a torn word.
   assign push_fire     = push_ok && last && !abort;
   assign pop_fire      = utq.o_utq_vld && utq.i_utq_acp && last;

`ifdef IDLI_UTQ_FLUSH_EN
   assign flush = i_utq_flush && last;
`else
   assign flush = 1'b0;
`endif

   always_ff @(posedge i_utq_gck) begin
      if (push_ok) begin
         mem[wr_ptr][{i_utq_ctr, 2'b00} +: 4] <= utq.i_utq_data;
      end
   end

   always_comb begin
      utq.o_utq_data = 4'h0;
      if (utq.o_utq_vld) begin
         utq.o_utq_data = mem[rd_ptr][{i_utq_ctr, 2'b00} +: 4];
      end
   end

   always_ff @(posedge i_utq_gck) begin
      if (i_utq_rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         abort  <= !last;
      end else begin
         if (last) begin
            abort <= 1'b0;
         end
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push_fire) begin
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_fire) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_fire && !pop_fire) begin
               count <= count + CW'(1);
            end else if (pop_fire && !push_fire) begin
               count <= count - CW'(1);
            end
         end
      end
   end

`ifndef SYNTHESIS
   logic chk_ok;
   logic vld_q;
   logic acp_q;

   always_ff @(posedge i_utq_gck) begin
      chk_ok <= !i_utq_rst;
      vld_q  <= utq.i_utq_vld;
      acp_q  <= utq.i_utq_acp;
      if (chk_ok && !i_utq_rst && i_utq_ctr != 2'd0) begin
         assert (utq.i_utq_vld == vld_q);
         assert (utq.i_utq_acp == acp_q);
      end
      if (chk_ok && !i_utq_rst) begin
         assert (count <= FULL);
         assert (!(pop_fire && !push_fire && count == '0));
      end
   end
`endif
endmodule

// File: tb/tb_idli_utq_m.sv
// Randomised bench for idli_utq_m: a word-level queue model feeds a per-cycle scoreboard checked by a monitor.
module tb_idli_utq_m;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic       acp;
      logic       vld;
      logic [3:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] ctr;
   logic       flush_in;

   idli_utq_if bus ();

   idli_utq_m #(.DEPTH(DEPTH)) dut (
      .i_utq_gck  (clk),
      .i_utq_rst  (rst),
      .i_utq_ctr  (ctr),
`ifdef IDLI_UTQ_FLUSH_EN
      .i_utq_flush(flush_in),
`endif
      .utq        (bus)
   );

   always #5 clk = ~clk;

   exp_t        exp_q[$];
   logic [15:0] word_exp_q[$];
   logic [15:0] mq[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   // Model works on whole words and whole periods; a reset inside a period
   // forces empty status for its remaining cycles and suppresses any commit.
   task automatic run_period(input bit v, input logic [15:0] w, input bit a,
                             input int rst_at, input bit fl);
      bit          acp0;
      bit          vld0;
      bit          cur_acp;
      bit          cur_vld;
      bit          aborted;
      logic [15:0] head;
      exp_t        e;
      acp0    = (mq.size() != DEPTH);
      vld0    = (mq.size() != 0);
      head    = vld0 ? mq[0] : 16'h0;
      cur_acp = acp0;
      cur_vld = vld0;
      aborted = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         ctr            = 2'(k);
         bus.i_utq_data = w[4*k +: 4];
         bus.i_utq_vld  = v;
         bus.i_utq_acp  = a;
         rst            = (k == rst_at);
         flush_in       = fl;
         e.acp  = cur_acp;
         e.vld  = cur_vld;
         e.data = cur_vld ? head[4*k +: 4] : 4'h0;
         exp_q.push_back(e);
         if (k == rst_at) begin
            aborted = 1'b1;
            cur_acp = 1'b1;
            cur_vld = 1'b0;
         end
      end
      if (aborted || fl) begin
         mq.delete();
      end else begin
         if (vld0 && a) word_exp_q.push_back(mq.pop_front());
         if (v && acp0) mq.push_back(w);
      end
   endtask

   task automatic idle(input int n, input bit a);
      for (int i = 0; i < n; i++) run_period(1'b0, 16'h0, a, -1, 1'b0);
   endtask

   // Monitor: one status comparison per checked cycle, one word comparison per delivered word.
   initial begin
      exp_t        e;
      logic [15:0] cur;
      logic [15:0] w;
      cur = 16'h0;
      forever begin
         @(negedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (bus.o_utq_acp !== e.acp || bus.o_utq_vld !== e.vld || bus.o_utq_data !== e.data) begin
               n_fail++;
               $display("FAIL status t=%0t ctr=%0d got acp=%b vld=%b data=%h expected acp=%b vld=%b data=%h",
                        $time, ctr, bus.o_utq_acp, bus.o_utq_vld, bus.o_utq_data, e.acp, e.vld, e.data);
            end
            cur[{ctr, 2'b00} +: 4] = bus.o_utq_data;
            if (ctr == 2'd3 && bus.o_utq_vld === 1'b1 && bus.i_utq_acp && !rst && !flush_in) begin
               n_tests++;
               if (word_exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL word t=%0t got %h expected no word", $time, cur);
               end else begin
                  w = word_exp_q.pop_front();
                  if (cur !== w) begin
                     n_fail++;
                     $display("FAIL word t=%0t got %h expected %h", $time, cur, w);
                  end
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      rst            = 1'b1;
      ctr            = 2'd3;
      flush_in       = 1'b0;
      bus.i_utq_data = 4'h0;
      bus.i_utq_vld  = 1'b0;
      bus.i_utq_acp  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         ctr = 2'(k);
         rst = 1'b1;
      end

      // Single word, presented the period after its push.
      run_period(1'b1, 16'hA5C3, 1'b1, -1, 1'b0);
      idle(2, 1'b1);

      // Fill and stall: fifth word refused.
      for (int i = 1; i <= 5; i++) run_period(1'b1, 16'(i), 1'b0, -1, 1'b0);
      idle(1, 1'b0);

      // Drain from full while pushing, pointers wrap.
      for (int i = 5; i <= 8; i++) run_period(1'b1, 16'(i), 1'b1, -1, 1'b0);
      idle(6, 1'b1);

      // Full with simultaneous pop: push refused, acp returns next period.
      for (int i = 0; i < 4; i++) run_period(1'b1, 16'h1100 + 16'(i), 1'b0, -1, 1'b0);
      run_period(1'b1, 16'h0F0F, 1'b1, -1, 1'b0);
      idle(1, 1'b0);
      idle(4, 1'b1);

      // Reset mid-period during a push with two words held.
      run_period(1'b1, 16'h1111, 1'b0, -1, 1'b0);
      run_period(1'b1, 16'h2222, 1'b0, -1, 1'b0);
      run_period(1'b1, 16'h3333, 1'b0, 1, 1'b0);
      run_period(1'b1, 16'h1234, 1'b1, -1, 1'b0);
      idle(2, 1'b1);

`ifdef IDLI_UTQ_FLUSH_EN
      for (int i = 0; i < 3; i++) run_period(1'b1, 16'h7700 + 16'(i), 1'b0, -1, 1'b0);
      run_period(1'b1, 16'hBEEF, 1'b1, -1, 1'b1);
      idle(2, 1'b1);
`endif

      for (int i = 0; i < 300; i++) begin
         bit v;
         bit a;
         bit fl;
         int ra;
         v  = ($urandom_range(0, 2) != 0);
         a  = ($urandom_range(0, 1) != 0);
         ra = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 3)) : -1;
         fl = 1'b0;
`ifdef IDLI_UTQ_FLUSH_EN
         fl = ($urandom_range(0, 29) == 0);
`endif
         run_period(v, 16'($urandom_range(0, 65535)), a, ra, fl);
      end
      idle(DEPTH + 2, 1'b1);

      @(negedge clk);
      #3;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL status_drain got %0d pending expected 0", exp_q.size());
      end
      n_tests++;
      if (word_exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL word_drain got %0d undelivered words expected 0", word_exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
